// File: rtl/mouse_receiver_if.sv
// PS/2 receive-side bundle: raw mouse lines, master enable and decoded byte outputs.
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [2:0] current_state;

  // Mouse master side: drives the lines and enable, consumes the decoded byte.
  modport master (
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY,
    input  current_state
  );

  // Receiver side.
  modport slave (
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY,
    output current_state
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames (start, 8 data LSB
// first, odd parity, stop) from the oversampled mouse clock into bytes.
module mouse_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  mouse_receiver_if.slave bus
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_fall;
  logic                   data_smp;

  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   par_err_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [7:0]             byte_q;
  logic [1:0]             err_q;
  logic                   rdy_q;

  // Synchronise both PS/2 lines; reset to the idle-high line level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.CLK_MOUSE_IN};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.DATA_MOUSE_IN};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  // Falling-edge detect on the synchronised PS/2 clock; data sampled in that cycle.
  always_comb begin
    clk_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    data_smp = data_sync_q[SYNC_STAGES-1];
  end

  // Frame FSM with bit counter, inter-edge timeout and registered byte outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      to_cnt_q  <= '0;
      byte_q    <= '0;
      err_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q  <= '0;
          bit_cnt_q <= '0;
          if (bus.READ_ENABLE && clk_fall && !data_smp) begin
            state_q <= DATA;
          end
        end
        DONE: begin
          to_cnt_q <= '0;
          state_q  <= IDLE;
        end
        default: begin
          if (!bus.READ_ENABLE) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
          end else if (clk_fall) begin
            to_cnt_q <= '0;
            case (state_q)
              DATA: begin
                shift_q   <= {data_smp, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  state_q <= PARITY;
                end
              end
              PARITY: begin
                par_err_q <= ~(^shift_q ^ data_smp);
                state_q   <= STOP;
              end
              STOP: begin
                // Outputs load on the stop edge so the registered strobe is
                // visible during the single DONE cycle.
                byte_q  <= shift_q;
                err_q   <= {~data_smp, par_err_q};
                rdy_q   <= 1'b1;
                state_q <= DONE;
              end
              default: state_q <= IDLE;
            endcase
          end else if (to_cnt_q == TO_LAST) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
      endcase
    end
  end

  // Drive registered values onto the bundle.
  always_comb begin
    bus.BYTE_READ       = byte_q;
    bus.BYTE_ERROR_CODE = err_q;
    bus.BYTE_READY      = rdy_q;
    bus.current_state   = state_q;
  end

endmodule
